// File: rtl/data_mem_responder.sv
// Data-memory slave with a fixed number of wait states per access and valid/ready channels.
// Optional feature macro: DMEM_BYTE_EN_EN adds req_be and per-byte store masking.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
`ifdef DMEM_BYTE_EN_EN
  input  logic [3:0]  req_be,
`endif
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);
  localparam int         IDX_W     = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        write_q, write_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [31:0] mem_q [DEPTH_WORDS];

  logic             accept, wait_done, do_access, mem_we;
  logic             acc_write, acc_err;
  logic [31:0]      acc_addr, acc_wdata;
  logic [3:0]       acc_be, be_in;
  logic [IDX_W-1:0] acc_idx;

`ifdef DMEM_BYTE_EN_EN
  assign be_in = req_be;
`else
  assign be_in = 4'hF;
`endif

  assign accept    = (state_q == IDLE) && req_valid;
  assign wait_done = (state_q == WAIT) && (cnt_q <= 4'd1);
  assign do_access = (accept && (WAIT_CYCLES == 0)) || wait_done;

  // With zero wait states the access happens on the accept edge, straight from the inputs.
  assign acc_write = (state_q == IDLE) ? req_write : write_q;
  assign acc_addr  = (state_q == IDLE) ? req_addr  : addr_q;
  assign acc_wdata = (state_q == IDLE) ? req_wdata : wdata_q;
  assign acc_be    = (state_q == IDLE) ? be_in     : be_q;
  assign acc_idx   = acc_addr[IDX_W+1:2];
  assign acc_err   = (acc_addr[1:0] != 2'b00) || ((acc_addr >> (IDX_W + 2)) != 32'd0);
  assign mem_we    = reset_n && do_access && acc_write && !acc_err;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          write_d = req_write;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          be_d    = be_in;
          cnt_d   = WAIT_INIT;
          state_d = (WAIT_CYCLES == 0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = RESP;
      end
      RESP: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (do_access) begin
      err_d   = acc_err;
      rdata_d = (acc_err || acc_write) ? 32'h0 : mem_q[acc_idx];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      write_q <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      be_q    <= 4'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Storage is never reset; it changes only on the access edge of a legal store.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (acc_be[b]) mem_q[acc_idx][8*b +: 8] <= acc_wdata[8*b +: 8];
      end
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule
